// File: rtl/serial_word_bridge.sv
// rtl/serial_word_bridge.sv - word-to-beat bridge: serialises writes and assembles reads over a narrow addressed bus
module serial_word_bridge #(
  parameter int unsigned       BUS_W     = 8,
  parameter int unsigned       WORD_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = '1,
  parameter bit                MSB_FIRST = 1'b0,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [BUS_W-1:0]  bus_in,
  input  logic              bus_valid_in,
  input  logic              bus_ready_in,
  output logic [BUS_W-1:0]  bus_out,
  output logic              bus_valid_out,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [WORD_W-1:0] rd_word,
  output logic              rd_done,
  output logic              wr_done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned BEATS  = WORD_W / BUS_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   asm_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [IDLE_W-1:0]   idle_q;

  logic [BEAT_W-1:0]   beat_nxt;
  logic                is_last;
  logic [WORD_W-1:0]   asm_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [BUS_W-1:0]    out_nxt;
  logic [BUS_W-1:0]    out_first;
  logic                stall_expired;

  // Bit lane carried by a given beat number.
  function automatic int unsigned lane_of(input logic [BEAT_W-1:0] beat);
    int unsigned b;
    b = 32'(beat);
    return MSB_FIRST ? (BEATS - 1 - b) : b;
  endfunction

  always_comb begin
    beat_nxt      = beat_q + BEAT_W'(1);
    is_last       = (beat_q == LAST_BEAT);
    asm_nxt       = asm_q;
    asm_nxt[lane_of(beat_q)*BUS_W +: BUS_W] = bus_in;
    addr_nxt      = base_q + ADDR_W'(beat_nxt);
    out_nxt       = wdata_q[lane_of(beat_nxt)*BUS_W +: BUS_W];
    out_first     = wr_word[lane_of(BEAT_W'(0))*BUS_W +: BUS_W];
    stall_expired = (TIMEOUT != 0) && (idle_q == IDLE_LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      wdata_q       <= '0;
      asm_q         <= '0;
      beat_q        <= '0;
      idle_q        <= '0;
      bus_out       <= '0;
      bus_valid_out <= 1'b0;
      bus_addr      <= IDLE_ADDR;
      rd_word       <= '0;
      rd_done       <= 1'b0;
      wr_done       <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      err     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_req) begin
            state_q       <= WR;
            base_q        <= base_addr;
            wdata_q       <= wr_word;
            beat_q        <= '0;
            idle_q        <= '0;
            bus_addr      <= base_addr;
            bus_out       <= out_first;
            bus_valid_out <= 1'b1;
            busy          <= 1'b1;
          end else if (rd_req) begin
            state_q  <= RD;
            base_q   <= base_addr;
            asm_q    <= '0;
            beat_q   <= '0;
            idle_q   <= '0;
            bus_addr <= base_addr;
            busy     <= 1'b1;
          end
        end

        RD: begin
          if (bus_valid_in) begin
            idle_q <= '0;
            asm_q  <= asm_nxt;
            if (is_last) begin
              rd_word  <= asm_nxt;
              rd_done  <= 1'b1;
              busy     <= 1'b0;
              beat_q   <= '0;
              bus_addr <= IDLE_ADDR;
              state_q  <= IDLE;
            end else begin
              beat_q   <= beat_nxt;
              bus_addr <= addr_nxt;
            end
          end else if (stall_expired) begin
            // Abort keeps the previous rd_word; the partial assembly is discarded.
            err      <= 1'b1;
            busy     <= 1'b0;
            beat_q   <= '0;
            idle_q   <= '0;
            bus_addr <= IDLE_ADDR;
            state_q  <= IDLE;
          end else if (TIMEOUT != 0) begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end

        WR: begin
          if (bus_ready_in) begin
            idle_q <= '0;
            if (is_last) begin
              wr_done       <= 1'b1;
              busy          <= 1'b0;
              bus_valid_out <= 1'b0;
              bus_out       <= '0;
              beat_q        <= '0;
              bus_addr      <= IDLE_ADDR;
              state_q       <= IDLE;
            end else begin
              beat_q   <= beat_nxt;
              bus_addr <= addr_nxt;
              bus_out  <= out_nxt;
            end
          end else if (stall_expired) begin
            err           <= 1'b1;
            busy          <= 1'b0;
            bus_valid_out <= 1'b0;
            bus_out       <= '0;
            beat_q        <= '0;
            idle_q        <= '0;
            bus_addr      <= IDLE_ADDR;
            state_q       <= IDLE;
          end else if (TIMEOUT != 0) begin
            idle_q <= idle_q + IDLE_W'(1);
          end
        end

        default: begin
          state_q       <= IDLE;
          busy          <= 1'b0;
          bus_valid_out <= 1'b0;
          bus_addr      <= IDLE_ADDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_bridge.sv
// tb/tb_serial_word_bridge.sv - directed bench: default, MSB-first and short-timeout instances on shared stimulus
module tb_serial_word_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [7:0]  base_addr;
  logic [31:0] wr_word;
  logic [7:0]  bus_in;
  logic        bus_valid_in, bus_ready_in;

  logic [7:0]  bus_out_o   [3];
  logic        bus_vout_o  [3];
  logic [7:0]  bus_addr_o  [3];
  logic [31:0] rd_word_o   [3];
  logic        rd_done_o   [3];
  logic        wr_done_o   [3];
  logic        busy_o      [3];
  logic        err_o       [3];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  serial_word_bridge u_def (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
    .base_addr(base_addr), .wr_word(wr_word), .bus_in(bus_in),
    .bus_valid_in(bus_valid_in), .bus_ready_in(bus_ready_in),
    .bus_out(bus_out_o[0]), .bus_valid_out(bus_vout_o[0]), .bus_addr(bus_addr_o[0]),
    .rd_word(rd_word_o[0]), .rd_done(rd_done_o[0]), .wr_done(wr_done_o[0]),
    .busy(busy_o[0]), .err(err_o[0])
  );

  serial_word_bridge #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
    .base_addr(base_addr), .wr_word(wr_word), .bus_in(bus_in),
    .bus_valid_in(bus_valid_in), .bus_ready_in(bus_ready_in),
    .bus_out(bus_out_o[1]), .bus_valid_out(bus_vout_o[1]), .bus_addr(bus_addr_o[1]),
    .rd_word(rd_word_o[1]), .rd_done(rd_done_o[1]), .wr_done(wr_done_o[1]),
    .busy(busy_o[1]), .err(err_o[1])
  );

  serial_word_bridge #(.TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
    .base_addr(base_addr), .wr_word(wr_word), .bus_in(bus_in),
    .bus_valid_in(bus_valid_in), .bus_ready_in(bus_ready_in),
    .bus_out(bus_out_o[2]), .bus_valid_out(bus_vout_o[2]), .bus_addr(bus_addr_o[2]),
    .rd_word(rd_word_o[2]), .rd_done(rd_done_o[2]), .wr_done(wr_done_o[2]),
    .busy(busy_o[2]), .err(err_o[2])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Four back-to-back beats; bytes[7:0] goes out first.
  task automatic do_read(input int idx, input logic [7:0] base, input logic [31:0] bytes);
    logic [7:0] a;
    rd_req    = 1'b1;
    base_addr = base;
    tick;
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = base + 8'(i);
      chk("rd_addr", 32'(bus_addr_o[idx]), 32'(a));
      chk("rd_busy", 32'(busy_o[idx]), 32'd1);
      chk("rd_done_early", 32'(rd_done_o[idx]), 32'd0);
      bus_valid_in = 1'b1;
      bus_in       = bytes[i*8 +: 8];
      tick;
    end
    bus_valid_in = 1'b0;
    chk("rd_done_pulse", 32'(rd_done_o[idx]), 32'd1);
    chk("rd_busy_end", 32'(busy_o[idx]), 32'd0);
    chk("rd_addr_idle", 32'(bus_addr_o[idx]), 32'hFF);
    tick;
    chk("rd_done_once", 32'(rd_done_o[idx]), 32'd0);
  endtask

  task automatic chk_wr(input logic [7:0] addr, input logic [7:0] data);
    chk("wr_addr", 32'(bus_addr_o[0]), 32'(addr));
    chk("wr_data", 32'(bus_out_o[0]), 32'(data));
    chk("wr_vout", 32'(bus_vout_o[0]), 32'd1);
    chk("wr_done_early", 32'(wr_done_o[0]), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; base_addr = '0; wr_word = '0;
    bus_in = '0; bus_valid_in = 1'b0; bus_ready_in = 1'b0;
    tick; tick;
    chk("rst_addr", 32'(bus_addr_o[0]), 32'hFF);
    chk("rst_out", 32'(bus_out_o[0]), 32'd0);
    chk("rst_vout", 32'(bus_vout_o[0]), 32'd0);
    chk("rst_rdword", rd_word_o[0], 32'd0);
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_err", 32'(err_o[0]), 32'd0);
    rst = 1'b0;
    tick;

    // Little- and big-lane assembly of the same stream
    do_read(0, 8'h20, 32'hDEADBEEF);
    chk("rdword_lsb", rd_word_o[0], 32'hDEADBEEF);
    chk("rdword_msb", rd_word_o[1], 32'hEFBEADDE);

    // Write with a two-cycle stall on beat 1
    wr_word = 32'h8D080004; base_addr = 8'h10; wr_req = 1'b1;
    tick;
    wr_req = 1'b0;
    chk("wr_busy", 32'(busy_o[0]), 32'd1);
    chk_wr(8'h10, 8'h04);
    bus_ready_in = 1'b1;
    tick;
    chk_wr(8'h11, 8'h00);
    bus_ready_in = 1'b0;
    tick;
    chk_wr(8'h11, 8'h00);
    tick;
    chk_wr(8'h11, 8'h00);
    bus_ready_in = 1'b1;
    tick;
    chk_wr(8'h12, 8'h08);
    tick;
    chk_wr(8'h13, 8'h8D);
    tick;
    chk("wr_done_pulse", 32'(wr_done_o[0]), 32'd1);
    chk("wr_vout_end", 32'(bus_vout_o[0]), 32'd0);
    chk("wr_busy_end", 32'(busy_o[0]), 32'd0);
    chk("wr_addr_idle", 32'(bus_addr_o[0]), 32'hFF);
    bus_ready_in = 1'b0;
    tick;
    chk("wr_done_once", 32'(wr_done_o[0]), 32'd0);
    chk("wr_rdword_kept", rd_word_o[0], 32'hDEADBEEF);

    // Address wrap through FF
    do_read(0, 8'hFE, 32'h44332211);
    chk("wrap_rdword", rd_word_o[0], 32'h44332211);
    chk("wrap_rdword_to", rd_word_o[2], 32'h44332211);

    // Timeout on the TIMEOUT=4 instance
    rd_req = 1'b1; base_addr = 8'h40;
    tick;
    rd_req = 1'b0;
    bus_valid_in = 1'b1; bus_in = 8'h5A;
    tick;
    bus_valid_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("to_err_early", 32'(err_o[2]), 32'd0);
      chk("to_busy_stall", 32'(busy_o[2]), 32'd1);
    end
    tick;
    chk("to_err_pulse", 32'(err_o[2]), 32'd1);
    chk("to_busy", 32'(busy_o[2]), 32'd0);
    chk("to_addr", 32'(bus_addr_o[2]), 32'hFF);
    chk("to_rd_done", 32'(rd_done_o[2]), 32'd0);
    chk("to_rdword", rd_word_o[2], 32'h44332211);
    tick;
    chk("to_err_once", 32'(err_o[2]), 32'd0);
    do_read(2, 8'h50, 32'h04030201);
    chk("to_next_rdword", rd_word_o[2], 32'h04030201);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;

    // Simultaneous requests: write wins
    rd_req = 1'b1; wr_req = 1'b1; wr_word = 32'hA5A51234; base_addr = 8'h30;
    tick;
    rd_req = 1'b0; wr_req = 1'b0;
    chk_wr(8'h30, 8'h34);
    bus_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("prio_no_rd_done", 32'(rd_done_o[0]), 32'd0);
    end
    chk("prio_wr_done", 32'(wr_done_o[0]), 32'd1);
    bus_ready_in = 1'b0;
    tick;
    chk("prio_idle", 32'(busy_o[0]), 32'd0);

    // Asynchronous reset after beat 2 of a read
    rd_req = 1'b1; base_addr = 8'h60;
    tick;
    rd_req = 1'b0;
    bus_valid_in = 1'b1;
    bus_in = 8'h11; tick;
    bus_in = 8'h22; tick;
    bus_in = 8'h33; tick;
    chk("mid_busy_before", 32'(busy_o[0]), 32'd1);
    chk("mid_addr_before", 32'(bus_addr_o[0]), 32'h63);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_o[0]), 32'd0);
    chk("mid_rst_addr", 32'(bus_addr_o[0]), 32'hFF);
    chk("mid_rst_rdword", rd_word_o[0], 32'd0);
    chk("mid_rst_err", 32'(err_o[0]), 32'd0);
    bus_valid_in = 1'b0;
    tick;
    chk("mid_rst_no_done", 32'(rd_done_o[0]), 32'd0);
    rst = 1'b0;
    tick;
    chk("post_rst_no_done", 32'(rd_done_o[0]), 32'd0);
    do_read(0, 8'h70, 32'h40302010);
    chk("post_rst_rdword", rd_word_o[0], 32'h40302010);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/serial_word_bridge.md
SERIAL_WORD_BRIDGE -- requirements
Module: serial_word_bridge

Interface
REQ-001 Parameter BUS_W, default 8: external bus width in bits.
REQ-002 Parameter WORD_W, default 32: word width in bits; SHALL be an integer multiple of BUS_W, with BEATS = WORD_W/BUS_W.
REQ-003 Parameter ADDR_W, default 8: external beat-address width in bits.
REQ-004 Parameter IDLE_ADDR, default all-ones: stall marker driven on bus_addr when not transferring.
REQ-005 Parameter MSB_FIRST, default 0: 0 means beat 0 is the least-significant lane; 1 means beat 0 is the most-significant lane.
REQ-006 Parameter TIMEOUT, default 255: maximum idle cycles inside a transfer; 0 disables the timeout.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 rd_req  in  1  request a read, sampled only in IDLE.
REQ-010 wr_req  in  1  request a write, sampled only in IDLE.
REQ-011 base_addr  in  ADDR_W  first beat address, captured with the request.
REQ-012 wr_word  in  WORD_W  write data, captured with wr_req.
REQ-013 bus_in  in  BUS_W  read beat data.
REQ-014 bus_valid_in  in  1  bus_in holds a valid beat this cycle.
REQ-015 bus_ready_in  in  1  external side accepts bus_out this cycle.
REQ-016 bus_out  out  BUS_W  write beat data.
REQ-017 bus_valid_out  out  1  bus_out holds a valid write beat.
REQ-018 bus_addr  out  ADDR_W  current beat address, or IDLE_ADDR.
REQ-019 rd_word  out  WORD_W  last completed read word.
REQ-020 rd_done  out  1  one-cycle read-completion pulse.
REQ-021 wr_done  out  1  one-cycle write-completion pulse.
REQ-022 busy  out  1  high while in RD or WR.
REQ-023 err  out  1  one-cycle timeout pulse.

Function
REQ-024 FSM states SHALL be IDLE, RD and WR; all outputs SHALL be registered.
REQ-025 In IDLE, a sampled wr_req (priority) or rd_req SHALL capture base_addr (and wr_word for a write), clear the beat counter and idle counter, and enter WR or RD at that edge.
REQ-026 Requests arriving outside IDLE SHALL be ignored and not queued.
REQ-027 bus_addr SHALL equal (captured base + beat) mod 2^ADDR_W in RD and WR, and IDLE_ADDR in IDLE.
REQ-028 RD: each edge with bus_valid_in=1 SHALL write bus_in into lane L and increment the beat counter; L = beat when MSB_FIRST=0, L = BEATS-1-beat when MSB_FIRST=1.
REQ-029 RD: the edge that samples beat BEATS-1 SHALL load the full assembled word into rd_word, pulse rd_done for one cycle, drop busy and return to IDLE.
REQ-030 rd_word SHALL change only on read completion; partial words SHALL NOT be visible.
REQ-031 WR: bus_valid_out SHALL be 1, and bus_out SHALL be lane L of the captured word, chosen by the REQ-028 rule.
REQ-032 WR: each edge with bus_ready_in=1 SHALL advance the beat; bus_out and bus_addr SHALL hold while bus_ready_in=0.
REQ-033 WR: acceptance of the last beat SHALL pulse wr_done for one cycle, clear bus_valid_out, drop busy and return to IDLE.
REQ-034 Minimum transfer latency SHALL be BEATS cycles from the first RD/WR cycle to the done pulse, i.e. 4 at default parameters.
REQ-035 Idle counter: SHALL count RD cycles with bus_valid_in=0 (or WR cycles with bus_ready_in=0) and reset on every beat.
REQ-036 When the idle counter reaches TIMEOUT (TIMEOUT>0), the FSM SHALL pulse err, abort to IDLE and leave rd_word unchanged, with no done pulse.
REQ-037 bus_valid_in in IDLE or WR, and bus_ready_in in IDLE or RD, SHALL be ignored.
REQ-038 Address wrap past 2^ADDR_W-1 SHALL be silent; an address equal to IDLE_ADDR during a transfer is legal and SHALL be qualified by busy.

Reset
REQ-039 Asserting rst SHALL immediately force: state IDLE, bus_addr=IDLE_ADDR, bus_out=0, bus_valid_out=0, rd_word=0, rd_done=0, wr_done=0, busy=0, err=0, all counters 0.
REQ-040 Reset mid-transfer SHALL abort with no done or err pulse; the first request after release SHALL be serviced normally.

Verification
REQ-041 Defaults; rd_req with base 0x20; bytes EF,BE,AD,DE on consecutive valid cycles -> bus_addr 20..23; rd_word=0xDEADBEEF; rd_done high exactly 1 cycle; bus_addr returns to 0xFF.
REQ-042 MSB_FIRST=1; same byte stream -> rd_word=0xEFBEADDE.
REQ-043 wr_req with wr_word=0x8D080004 and base 0x10; bus_ready_in low for 2 cycles after beat 1 -> bus_out 04,00,08,8D at addr 10..13; beat 1 held stable while stalled; wr_done after 6 cycles.
REQ-044 base 0xFE read -> addresses FE, FF, 00, 01; completes correctly.
REQ-045 TIMEOUT=4; beat 0 supplied, then bus_valid_in low -> err pulse on the 4th idle cycle; rd_word unchanged; busy=0; a subsequent read succeeds.
REQ-046 rd_req and wr_req together -> WR taken and RD dropped; rst asserted after beat 2 of a read -> all outputs at reset values, no rd_done pulse.
